// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: four-digit packed-BCD down-counter with a prescaled tick, load, start/stop and a done pulse.
// Digits 3..0 sit at [15:12]..[3:0]. Every loaded value is clamped so the count never shows a non-BCD digit.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [15:0] din_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        dec_i,
    output logic [15:0] count_o,
    output logic        zero_o,
    output logic        running_o,
    output logic        expired_o,
    output logic        done_o
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_EXP  = 2'd2;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;
    logic [15:0]   count_dec;
    logic          idle, run, nonzero, tick;

    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    // Ripple borrow: zero digits become 9 until the first nonzero digit absorbs the borrow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign idle      = (state_q == S_IDLE);
    assign run       = (state_q == S_RUN);
    assign nonzero   = (count_q != 16'h0000);
    assign tick      = run && (pre_q == PRE_LAST);
    assign count_dec = bcd_dec(count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        if (load_i) begin
            count_d = bcd_clamp(din_i);
            pre_d   = '0;
            state_d = S_IDLE;
        end else if (stop_i && run) begin
            state_d = S_IDLE;
            pre_d   = '0;
        end else if (start_i && !stop_i && idle && nonzero) begin
            state_d = S_RUN;
            pre_d   = '0;
        end else if (dec_i && idle && nonzero) begin
            count_d = count_dec;
        end else if (run) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                count_d = count_dec;
                if (count_dec == 16'h0000) begin
                    state_d = S_EXP;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            count_q <= 16'h0000;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    assign count_o   = count_q;
    assign zero_o    = (count_q == 16'h0000);
    assign running_o = run;
    assign expired_o = (state_q == S_EXP);
    assign done_o    = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed vector table plus hand sequences for pause, manual step and async reset.
module tb_bcd_countdown_timer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0, start = 1'b0, stop = 1'b0, dec = 1'b0;
    logic [15:0] din = 16'h0000;
    logic [15:0] count;
    logic        zero, running, expired, done;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        ld;
        logic [15:0] din;
        logic        st, sp, dc;
        logic [15:0] cnt;
        logic        z, r, e, d;
    } vec_t;
    vec_t tv[$];

    bcd_countdown_timer #(.TICK_DIV(4)) dut (
        .clk_i(clk), .reset_i(reset), .load_i(load), .din_i(din),
        .start_i(start), .stop_i(stop), .dec_i(dec),
        .count_o(count), .zero_o(zero), .running_o(running),
        .expired_o(expired), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] c, input logic z, input logic r,
                           input logic e, input logic d);
        chk({tag, " count"}, count, c);
        chk({tag, " zero"}, 16'(zero), 16'(z));
        chk({tag, " running"}, 16'(running), 16'(r));
        chk({tag, " expired"}, 16'(expired), 16'(e));
        chk({tag, " done"}, 16'(done), 16'(d));
    endtask

    task automatic step(input logic ld, input logic [15:0] d, input logic st, input logic sp, input logic dc);
        load = ld; din = d; start = st; stop = sp; dec = dc;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; stop = 1'b0; dec = 1'b0;
    endtask

    task automatic add(input logic ld, input logic [15:0] d, input logic st, input logic sp, input logic dc,
                       input logic [15:0] c, input logic z, input logic r, input logic e, input logic dn);
        vec_t v;
        v.ld = ld; v.din = d; v.st = st; v.sp = sp; v.dc = dc;
        v.cnt = c; v.z = z; v.r = r; v.e = e; v.d = dn;
        tv.push_back(v);
    endtask

    initial begin
        // load / clamp
        add(1, 16'h0012, 0, 0, 0, 16'h0012, 0, 0, 0, 0);
        add(1, 16'hFFFF, 0, 0, 0, 16'h9999, 0, 0, 0, 0);
        add(1, 16'h1A3F, 0, 0, 0, 16'h1939, 0, 0, 0, 0);
        // borrow chain
        add(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h1000, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 16'h0000, 0, 0, 0, 16'h1000, 0, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 16'h0999, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 16'h0000, 0, 0, 0, 16'h0999, 0, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 16'h0998, 0, 1, 0, 0);
        // expiry
        add(1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0002, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 16'h0000, 0, 0, 0, 16'h0002, 0, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 16'h0001, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 16'h0000, 0, 0, 0, 16'h0001, 0, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 1, 1);
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 1, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 1, 0);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 1, 0);
        // manual step, including borrow and no wrap below zero
        add(1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0009, 0, 0, 0, 0);
        add(1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 0);
        // load on a tick edge discards the decrement
        add(1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0002, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 16'h0000, 0, 0, 0, 16'h0002, 0, 1, 0, 0);
        add(1, 16'h0050, 0, 0, 0, 16'h0050, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 16'h0050, 0, 0, 0, 0);

        reset = 1'b1;
        #12;
        chk_all("reset", 16'h0000, 1, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        foreach (tv[i]) begin
            step(tv[i].ld, tv[i].din, tv[i].st, tv[i].sp, tv[i].dc);
            chk_all($sformatf("row%0d", i), tv[i].cnt, tv[i].z, tv[i].r, tv[i].e, tv[i].d);
        end

        // pause and resume: the partial step before Stop is discarded
        step(1, 16'h0005, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("pause running", 16'(running), 16'h0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("pause hold%0d", i), count, 16'h0005);
        end
        step(0, 0, 1, 0, 0);
        chk("resume running", 16'(running), 16'h1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("resume wait%0d", i), count, 16'h0005);
        end
        step(0, 0, 0, 0, 0);
        chk("resume step", count, 16'h0004);
        step(0, 0, 1, 1, 0);
        chk("start+stop running", 16'(running), 16'h0);
        chk("start+stop count", count, 16'h0004);

        // DEC while running is ignored and does not disturb the prescaler
        step(1, 16'h0003, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("run dec count", count, 16'h0003);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("run dec still", count, 16'h0003);
        step(0, 0, 0, 0, 0);
        chk("run dec tick", count, 16'h0002);

        // async reset between edges
        step(1, 16'h0300, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async reset", 16'h0000, 1, 0, 0, 0);
        reset = 1'b0;
        step(0, 0, 1, 0, 0);
        chk("post reset start", 16'(running), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
